argmax_frame_sequencer: RTL and testbench

Sequential front end for the classifier output stage. It accepts the output-layer class scores as a serial valid/ready stream, one score per beat, and keeps a running maximum. At frame end it presents the winning digit index and its score on a valid/ready result port. It sits between the serial dense-layer accumulator and the digit display/UART logic, and replaces the combinational 10-way compare tree when scores arrive serially.

---
 rtl/argmax_frame_sequencer.sv | 132 +++++++++++++
 tb/tb_argmax_frame_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_frame_sequencer.sv
// argmax_frame_sequencer
// Serial argmax over one frame of class scores. Scores arrive one per beat
// on a valid/ready stream. The winning index and its score are then held on a
// valid/ready result port until the consumer takes them.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A producer holds its data stable while valid is high and ready is low.
// s_ready depends only on the state. m_valid is also state-derived, so there
// is no combinational path from s_* to m_*.

`timescale 1ns/1ps

module argmax_frame_sequencer #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 8,
    parameter int DIGIT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SCORE_W-1:0] s_score,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DIGIT_W-1:0] m_digit,
    output logic [SCORE_W-1:0] m_max_score,
    output logic               m_frame_err,
    output logic               busy
);

    localparam int CW = $clog2(N_CLASSES) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      k, k_nx;
    logic [SCORE_W-1:0] max_r, max_nx;
    logic [CW-1:0]      idx_r, idx_nx;
    logic [SCORE_W-1:0] cand_max;
    logic [CW-1:0]      cand_idx;
    logic               beat;
    logic               last_k;
    logic               end_beat;
    logic               load_result;

    assign s_ready  = (state != HOLD);
    assign m_valid  = (state == HOLD);
    assign busy     = (state != IDLE);
    assign beat     = s_valid && s_ready;
    assign last_k   = (k == CW'(N_CLASSES - 1));
    // Frame ends on the producer's marker or when the counter forces closure.
    assign end_beat = s_last || last_k;

    // Running max including the current beat; the first beat always loads, and ties keep the older index.
    always_comb begin
        cand_max = max_r;
        cand_idx = idx_r;
        if (state == IDLE) begin
            cand_max = s_score;
            cand_idx = '0;
        end else if (s_score > max_r) begin
            cand_max = s_score;
            cand_idx = k;
        end
    end

    // Next-state, counter and running-max update logic.
    always_comb begin
        state_nx    = state;
        k_nx        = k;
        max_nx      = max_r;
        idx_nx      = idx_r;
        load_result = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    max_nx = cand_max;
                    idx_nx = cand_idx;
                    if (end_beat) begin
                        state_nx    = HOLD;
                        k_nx        = '0;
                        load_result = 1'b1;
                    end else begin
                        state_nx = ACCUM;
                        k_nx     = k + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nx = IDLE;
                    k_nx     = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                k_nx     = '0;
            end
        endcase
    end

    // State, counter and running max registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            max_r <= '0;
            idx_r <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            max_r <= max_nx;
            idx_r <= idx_nx;
        end
    end

    // Result registers load on the end beat and keep their value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digit     <= '0;
            m_max_score <= '0;
            m_frame_err <= 1'b0;
        end else if (load_result) begin
            m_digit     <= DIGIT_W'(cand_idx);
            m_max_score <= cand_max;
            // The length is wrong when exactly one of the two closing conditions holds.
            m_frame_err <= s_last ^ last_k;
        end
    end

endmodule

// File: tb/tb_argmax_frame_sequencer.sv
// Testbench for argmax_frame_sequencer: directed frames followed by random frames.
// The random frames are compared against an argmax reference model.

`timescale 1ns/1ps

module tb_argmax_frame_sequencer;

    localparam int N  = 10;
    localparam int SW = 8;
    localparam int DW = 8;
    localparam int NF = 500;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic [SW-1:0] s_score = '0;
    logic          m_ready = 1'b0;
    logic          s_ready, m_valid, m_frame_err, busy;
    logic [DW-1:0] m_digit;
    logic [SW-1:0] m_max_score;

    int checks   = 0;
    int failures = 0;
    bit rand_ready_en = 1'b0;

    // scoreboard: {err, digit, max}
    logic [16:0] exp_q[$];
    logic [16:0] res_q[$];
    logic [SW-1:0] sc[$];

    argmax_frame_sequencer #(.N_CLASSES(N), .SCORE_W(SW), .DIGIT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit),
        .m_max_score(m_max_score), .m_frame_err(m_frame_err), .busy(busy)
    );

    // Result monitor: a handshake occurs at the posedge following this sample.
    always @(negedge clk)
        if (rst_n && m_valid && m_ready)
            res_q.push_back({m_frame_err, m_digit, m_max_score});

    // Random consumer readiness during the random phase.
    always @(posedge clk)
        if (rand_ready_en) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; return just after the accepting edge.
    task automatic send_beat(input logic [SW-1:0] score, input logic last);
        int waits = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_score = score;
        s_last  = last;
        while (!s_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!s_ready) check("beat_accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] q[$], input bit last_on_end, input int max_gap);
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_beat(q[i], last_on_end && (i == q.size() - 1));
        end
    endtask

    // Reference: the largest value, reported at its lowest index. The frame is
    // well formed only when it carries exactly N beats with the last one marked.
    function automatic logic [16:0] model(input logic [SW-1:0] q[$], input bit last_given);
        logic [SW-1:0] mx;
        int d;
        logic err;
        mx = '0;
        foreach (q[i]) if (q[i] > mx) mx = q[i];
        d = 0;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i] == mx) d = i;
        err = !(q.size() == N && last_given);
        return {err, 8'(d), mx};
    endfunction

    task automatic check_result(input string tag, input logic [16:0] exp);
        check({tag, "_digit"}, 32'(m_digit), 32'(exp[15:8]));
        check({tag, "_max"},   32'(m_max_score), 32'(exp[7:0]));
        check({tag, "_err"},   32'(m_frame_err), 32'(exp[16]));
    endtask

    initial begin
        logic [16:0] e;
        int n0;
        int budget;
        bit long_last;
        int len;

        // reset values
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_digit", 32'(m_digit), 0);
        check("rst_m_max",   32'(m_max_score), 0);
        check("rst_m_err",   32'(m_frame_err), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_busy",    32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // basic frame, consumer ready
        @(posedge clk); #1 m_ready = 1'b1;
        sc = '{3, 9, 1, 200, 7, 7, 0, 5, 199, 2};
        send_frame(sc, 1'b1, 0);
        @(negedge clk);
        check("basic_m_valid", 32'(m_valid), 1);
        check("basic_s_ready_low", 32'(s_ready), 0);
        check("basic_busy", 32'(busy), 1);
        check_result("basic", {1'b0, 8'd3, 8'd200});
        @(negedge clk);
        check("basic_m_valid_drop", 32'(m_valid), 0);
        check("basic_s_ready_back", 32'(s_ready), 1);
        check("basic_busy_idle", 32'(busy), 0);
        check("basic_digit_retained", 32'(m_digit), 3);

        // ties keep the lower index
        sc = '{50, 80, 80, 10, 80, 0, 0, 0, 0, 80};
        send_frame(sc, 1'b1, 1);
        @(negedge clk);
        check_result("tie", {1'b0, 8'd1, 8'd80});

        // all-zero frame
        sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(sc, 1'b1, 0);
        @(negedge clk);
        check_result("zero", {1'b0, 8'd0, 8'd0});

        // backpressure: result held for 20 cycles
        @(posedge clk); #1 m_ready = 1'b0;
        sc = '{10, 20, 30, 40, 250, 60, 70, 80, 90, 100};
        send_frame(sc, 1'b1, 0);
        repeat (20) begin
            @(negedge clk);
            check("bp_m_valid", 32'(m_valid), 1);
            check("bp_s_ready", 32'(s_ready), 0);
            check_result("bp", {1'b0, 8'd4, 8'd250});
        end
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(m_valid), 1);
        @(negedge clk);
        check("bp_idle_valid", 32'(m_valid), 0);
        check("bp_idle_s_ready", 32'(s_ready), 1);

        // short frame
        sc = '{1, 2, 3, 4, 9, 5};
        send_frame(sc, 1'b1, 0);
        @(negedge clk);
        check("short_m_valid", 32'(m_valid), 1);
        check_result("short", {1'b1, 8'd4, 8'd9});

        // long frame with no last marker: force-closed at beat N
        sc.delete();
        for (int i = 0; i < N; i++) sc.push_back(SW'($urandom_range(0, 255)));
        send_frame(sc, 1'b0, 1);
        @(negedge clk);
        check("long_m_valid", 32'(m_valid), 1);
        check("long_s_ready", 32'(s_ready), 0);
        check_result("long", model(sc, 1'b0));

        // single-beat frame
        send_beat(8'd77, 1'b1);
        @(negedge clk);
        check_result("single", {1'b1, 8'd0, 8'd77});

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_beat(SW'(100 + i), 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_m_digit", 32'(m_digit), 0);
        check("midrst_m_max",   32'(m_max_score), 0);
        check("midrst_m_err",   32'(m_frame_err), 0);
        check("midrst_s_ready", 32'(s_ready), 1);
        check("midrst_busy",    32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        n0 = res_q.size();
        sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_frame(sc, 1'b1, 0);
        @(negedge clk);
        check_result("postrst", {1'b0, 8'd9, 8'd9});
        repeat (3) @(posedge clk);
        check("postrst_result_count", 32'(res_q.size() - n0), 1);
        if (res_q.size() > 0) check("postrst_result", 32'(res_q[$]), 32'({1'b0, 8'd9, 8'd9}));

        // random frames, random gaps, random consumer readiness
        @(posedge clk);
        res_q.delete();
        exp_q.delete();
        rand_ready_en = 1'b1;
        for (int f = 0; f < NF; f++) begin
            len = $urandom_range(1, N);
            long_last = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
            sc.delete();
            for (int i = 0; i < len; i++)
                sc.push_back(SW'($urandom_range(0, (f % 3 == 0) ? 3 : 255)));
            exp_q.push_back(model(sc, long_last));
            send_frame(sc, long_last, 2);
        end
        budget = 0;
        while (res_q.size() < NF && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        rand_ready_en = 1'b0;
        check("rand_result_count", 32'(res_q.size()), 32'(NF));
        for (int i = 0; i < NF && i < res_q.size(); i++) begin
            e = exp_q[i];
            check($sformatf("rand_frame_%0d", i), 32'(res_q[i]), 32'(e));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
